uart_pwm_cmd_ctrl: RTL and testbench
====================================

Name: uart_pwm_cmd_ctrl

Overview:
- Command controller between `uart_rx` / `uart_tx` and the PWM channel bank.
- Parses framed write commands from the received byte stream and checks each frame's checksum.
- Updates the PWM period, per-channel duty and enable registers atomically.
- Answers every complete frame with a single ACK or NAK byte through the UART transmitter.

Parameters:
- NUM_CH, 4: number of PWM channels (1..16).
- PWM_W, 16: width of the period and duty registers.
- PERIOD_RST, 1000: reset value of pwm_period.
- TIMEOUT_CYC, 50000: maximum idle clocks between bytes inside a frame (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from uart_rx data_out.
- rx_valid  in  1  one-cycle strobe from uart_rx data_valid.
- tx_data  out  8  response byte to uart_tx.
- tx_start  out  1  one-cycle request to uart_tx.
- tx_busy  in  1  uart_tx is transmitting.
- pwm_period  out  PWM_W  PWM period register.
- pwm_duty  out  NUM_CH*PWM_W  duty registers; channel n occupies bits [n*PWM_W +: PWM_W].
- pwm_en  out  NUM_CH  channel enable mask.
- cfg_update  out  1  one-cycle pulse when any register changes.
- frame_err  out  1  one-cycle pulse on checksum error, timeout or rejected command.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - pwm_period = PERIOD_RST; all duties = 0; pwm_en = 0.
  - tx_data = 0; tx_start = 0; cfg_update = 0; frame_err = 0.
- Frame format: SYNC 0xA5, CMD, DHI, DLO, CHK.
  - Checksum: CHK must equal CMD ^ DHI ^ DLO.
  - Data value: D = {DHI, DLO}. For PWM_W < 16 use the low PWM_W bits; upper bits must be 0 or the command is NAKed.
- Commands:
  - 0x1n: set duty of channel n to D.
    - NAK if n >= NUM_CH or D > pwm_period.
  - 0x20: set period to D.
    - NAK if D == 0.
    - Existing duties are left unchanged; duty >= period means 100 % in the PWM.
  - 0x30: set enable mask to DLO[NUM_CH-1:0].
    - DHI is ignored.
  - Any other CMD: NAK.
  - ACK byte = 0x06, NAK byte = 0x15.
- States:
  - IDLE: waits for rx_valid with rx_data == 0xA5 and goes to CMD; all other bytes are discarded silently.
  - CMD, DHI, DLO, CHK: each captures one byte on rx_valid and advances.
  - EXEC (one cycle): checks the command. If valid, writes the register, pulses cfg_update and loads tx_data = ACK. Otherwise loads NAK and pulses frame_err.
  - RESP: waits for tx_busy = 0, pulses tx_start for one cycle, then goes to IDLE.
- Latency, with the CHK byte's rx_valid at cycle T:
  - Register update and cfg_update at T+1.
  - tx_start no earlier than T+2.
- Checksum mismatch: EXEC loads NAK, pulses frame_err, registers untouched.
- Timeout:
  - Counter clears on every rx_valid and counts only in CMD, DHI, DLO and CHK.
  - Reaching TIMEOUT_CYC returns the FSM to IDLE, pulses frame_err and sends no response.
- rx_valid during EXEC or RESP: byte dropped and not re-parsed as SYNC.
- 0xA5 appearing inside a frame is treated as data; there is no resynchronisation mid-frame.
- Register writes are atomic: the full PWM_W-bit value is written in one clock; the PWM never sees a half-written value.
- Reset mid-frame or mid-response: the FSM aborts and no tx_start is issued after reset.

Decomposition:
- Shared header `uart_pwm_defs.vh`, used by the UART, PWM and this block:
  - Constants SYNC_BYTE, OP_DUTY=4'h1, OP_PERIOD=8'h20, OP_ENABLE=8'h30, ACK_BYTE, NAK_BYTE.
  - FSM state encodings.
- One sub-module, `uart_byte_timeout`: inter-byte timeout counter with parameter TIMEOUT_CYC.
  - Inputs: clk, rst, run, clear.
  - Output: expired (one-cycle pulse).

Test Plan (drive uart_rx with BAUD_DIV=434; check every response on the uart_tx line):
1. After reset, send A5 11 01 F4 E4 -> duty ch1 = 500, cfg_update pulses once, response 0x06, other duties 0, pwm_period = 1000.
2. Send A5 20 03 E8 CB, then A5 30 00 0F 3F -> period = 1000, pwm_en = 4'hF, two ACK bytes.
3. Send A5 11 01 F4 00 (bad checksum) -> response 0x15, frame_err pulse, duty ch1 unchanged, no cfg_update.
4. Send A5 12 07 D0 C5 (duty 2000 > period) and A5 14 00 10 04 (channel 4 >= NUM_CH) -> two NAKs, registers unchanged.
5. Send A5 11, then idle for more than TIMEOUT_CYC clocks, then A5 10 00 64 74 -> first frame dropped with one frame_err and no response; second frame gives ch0 = 100 and ACK.
6. Assert rst low while DHI is arriving -> all outputs return to reset values and no response byte is sent; a following valid frame is accepted normally.

Source files
------------

// File: rtl/uart_pwm_cmd_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART-to-PWM command path.
// Frame: SYNC, CMD, DHI, DLO, CHK with CHK = CMD ^ DHI ^ DLO.
package uart_pwm_cmd_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [3:0] OP_DUTY   = 4'h1;
    localparam logic [7:0] OP_PERIOD = 8'h20;
    localparam logic [7:0] OP_ENABLE = 8'h30;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DHI,
        ST_DLO,
        ST_CHK,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic [7:0] frame_chk(
        input logic [7:0] c,
        input logic [7:0] h,
        input logic [7:0] l
    );
        return c ^ h ^ l;
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: pulses expired after TIMEOUT_CYC idle clocks
// while run is high; clear restarts the count.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = run && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// Frame parser and register file between the UART and the PWM bank.
// Each complete frame is answered with exactly one ACK or NAK byte.
module uart_pwm_cmd_ctrl
    import uart_pwm_cmd_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PWM_W       = 16,
    parameter int PERIOD_RST  = 1000,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [PWM_W-1:0]        pwm_period,
    output logic [NUM_CH*PWM_W-1:0] pwm_duty,
    output logic [NUM_CH-1:0]       pwm_en,
    output logic                    cfg_update,
    output logic                    frame_err
);

    state_t state_q, state_d;

    logic [7:0] cmd_q, dhi_q, dlo_q;
    logic [PWM_W-1:0] duty_q [NUM_CH];

    logic        expired;
    logic        run;
    logic [15:0] d16;
    logic [PWM_W-1:0] d_val;
    logic        hi_ok;
    logic        chk_ok;
    logic [3:0]  ch;
    logic        ch_ok;
    logic        is_duty, is_period, is_enable;
    logic        wr_duty, wr_period, wr_en;
    logic        last;
    logic        accept;

    assign run = (state_q == ST_CMD) || (state_q == ST_DHI) ||
                 (state_q == ST_DLO) || (state_q == ST_CHK);

    uart_byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clear  (rx_valid),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD: begin
                if (expired)       state_d = ST_IDLE;
                else if (rx_valid) state_d = ST_DHI;
            end
            ST_DHI: begin
                if (expired)       state_d = ST_IDLE;
                else if (rx_valid) state_d = ST_DLO;
            end
            ST_DLO: begin
                if (expired)       state_d = ST_IDLE;
                else if (rx_valid) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (expired)       state_d = ST_IDLE;
                else if (rx_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (!tx_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
            dhi_q <= '0;
            dlo_q <= '0;
        end else if (rx_valid) begin
            if (state_q == ST_CMD) cmd_q <= rx_data;
            if (state_q == ST_DHI) dhi_q <= rx_data;
            if (state_q == ST_DLO) dlo_q <= rx_data;
        end
    end

    // Validation runs while the CHK byte is on rx_data so the write
    // and cfg_update are already visible during the EXEC cycle.
    assign d16       = {dhi_q, dlo_q};
    assign d_val     = PWM_W'(d16);
    assign hi_ok     = ((32'(d16) >> PWM_W) == 32'd0);
    assign chk_ok    = (rx_data == frame_chk(cmd_q, dhi_q, dlo_q));
    assign ch        = cmd_q[3:0];
    assign ch_ok     = ({28'd0, ch} < 32'(NUM_CH));
    assign is_duty   = (cmd_q[7:4] == OP_DUTY);
    assign is_period = (cmd_q == OP_PERIOD);
    assign is_enable = (cmd_q == OP_ENABLE);
    assign last      = (state_q == ST_CHK) && rx_valid;

    always_comb begin
        wr_duty   = 1'b0;
        wr_period = 1'b0;
        wr_en     = 1'b0;
        unique case (1'b1)
            is_duty:   wr_duty   = ch_ok && hi_ok && (d_val <= pwm_period);
            is_period: wr_period = hi_ok && (d_val != '0);
            is_enable: wr_en     = 1'b1;
            default:   ;
        endcase
    end

    assign accept = chk_ok && (wr_duty || wr_period || wr_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_period <= PWM_W'(PERIOD_RST);
            pwm_en     <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) duty_q[n] <= '0;
        end else begin
            tx_start   <= (state_q == ST_RESP) && !tx_busy;
            cfg_update <= 1'b0;
            frame_err  <= expired;
            if (last) begin
                if (accept) begin
                    tx_data    <= ACK_BYTE;
                    cfg_update <= 1'b1;
                end else begin
                    tx_data    <= NAK_BYTE;
                    frame_err  <= 1'b1;
                end
                if (accept && wr_period) pwm_period <= d_val;
                if (accept && wr_en)     pwm_en     <= NUM_CH'(dlo_q);
                for (int n = 0; n < NUM_CH; n++) begin
                    if (accept && wr_duty && ch == 4'(n)) duty_q[n] <= d_val;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
        assign pwm_duty[g*PWM_W +: PWM_W] = duty_q[g];
    end

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// Scoreboard bench for uart_pwm_cmd_ctrl: frames in, ACK/NAK bytes
// and register contents checked against hand-computed values.
module tb_uart_pwm_cmd_ctrl;

    localparam int NUM_CH = 4;
    localparam int PWM_W  = 16;
    localparam int TO     = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [7:0]              rx_data = 8'h00;
    logic                    rx_valid = 1'b0;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_busy = 1'b0;
    logic [PWM_W-1:0]        pwm_period;
    logic [NUM_CH*PWM_W-1:0] pwm_duty;
    logic [NUM_CH-1:0]       pwm_en;
    logic                    cfg_update;
    logic                    frame_err;

    uart_pwm_cmd_ctrl #(
        .NUM_CH     (NUM_CH),
        .PWM_W      (PWM_W),
        .PERIOD_RST (1000),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .pwm_period(pwm_period),
        .pwm_duty  (pwm_duty),
        .pwm_en    (pwm_en),
        .cfg_update(cfg_update),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cfg_cnt = 0;
    int err_cnt = 0;
    int exp_cfg = 0;
    int exp_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [PWM_W-1:0] duty(input int n);
        return pwm_duty[n*PWM_W +: PWM_W];
    endfunction

    // Response monitor: every tx_start pops one expected byte
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (cfg_update) cfg_cnt++;
            if (frame_err)  err_cnt++;
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_tx: got byte %0h required none",
                             tx_data);
                end else begin
                    chk("resp", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Minimal uart_tx stand-in: busy for 20 clocks after each start
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            tx_busy = 1'b1;
            repeat (20) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap_byte(input logic [7:0] b);
        repeat (3) @(negedge clk);
        send_byte(b);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] k);
        gap_byte(8'hA5);
        gap_byte(c);
        gap_byte(h);
        gap_byte(l);
        gap_byte(k);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL resp_timeout: got %0d outstanding required 0",
                     exp_q.size());
            exp_q.delete();
        end
        repeat (25) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(pwm_period), 1000);
        chk("rst_duty", 32'(pwm_duty == '0), 1);
        chk("rst_en", 32'(pwm_en), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_pulses", {29'd0, tx_start, cfg_update, frame_err}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        exp_q.push_back(8'h06);
        frame(8'h11, 8'h01, 8'hF4, 8'hE4);
        exp_cfg++;
        chk("t1_cfg_lat", 32'(cfg_update), 1);
        chk("t1_duty1", 32'(duty(1)), 500);
        wait_resp();
        chk("t1_duty0", 32'(duty(0)), 0);
        chk("t1_duty23", {duty(3), duty(2)}, 0);
        chk("t1_period", 32'(pwm_period), 1000);
        chk("t1_cfg_cnt", cfg_cnt, exp_cfg);

        exp_q.push_back(8'h06);
        frame(8'h20, 8'h03, 8'hE8, 8'hCB);
        send_byte(8'hA5);
        exp_cfg++;
        wait_resp();
        exp_q.push_back(8'h06);
        frame(8'h30, 8'h00, 8'h0F, 8'h3F);
        exp_cfg++;
        wait_resp();
        chk("t2_period", 32'(pwm_period), 1000);
        chk("t2_en", 32'(pwm_en), 32'hF);
        chk("t2_cfg_cnt", cfg_cnt, exp_cfg);

        exp_q.push_back(8'h15);
        frame(8'h11, 8'h01, 8'hF4, 8'h00);
        exp_err++;
        chk("t3_err_lat", 32'(frame_err), 1);
        wait_resp();
        chk("t3_duty1", 32'(duty(1)), 500);
        chk("t3_cfg_cnt", cfg_cnt, exp_cfg);

        exp_q.push_back(8'h15);
        frame(8'h12, 8'h07, 8'hD0, 8'hC5);
        wait_resp();
        exp_q.push_back(8'h15);
        frame(8'h14, 8'h00, 8'h10, 8'h04);
        wait_resp();
        exp_q.push_back(8'h15);
        frame(8'h20, 8'h00, 8'h00, 8'h20);
        wait_resp();
        exp_q.push_back(8'h15);
        frame(8'h40, 8'h00, 8'h00, 8'h40);
        wait_resp();
        exp_err += 4;
        chk("t4_duty2", 32'(duty(2)), 0);
        chk("t4_period", 32'(pwm_period), 1000);
        chk("t4_err_cnt", err_cnt, exp_err);
        chk("t4_cfg_cnt", cfg_cnt, exp_cfg);

        gap_byte(8'hA5);
        gap_byte(8'h11);
        repeat (TO + 50) @(negedge clk);
        exp_err++;
        chk("t5_timeout_err", err_cnt, exp_err);
        exp_q.push_back(8'h06);
        frame(8'h10, 8'h00, 8'h64, 8'h74);
        exp_cfg++;
        wait_resp();
        chk("t5_duty0", 32'(duty(0)), 100);
        chk("t5_duty1", 32'(duty(1)), 500);
        chk("t5_cfg_cnt", cfg_cnt, exp_cfg);

        gap_byte(8'hA5);
        gap_byte(8'h11);
        repeat (3) @(negedge clk);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t6_period", 32'(pwm_period), 1000);
        chk("t6_duty", 32'(pwm_duty == '0), 1);
        chk("t6_en", 32'(pwm_en), 0);
        chk("t6_tx_data", 32'(tx_data), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        exp_q.push_back(8'h06);
        frame(8'h20, 8'h01, 8'hF4, 8'hD5);
        exp_cfg++;
        wait_resp();
        chk("t6_period_new", 32'(pwm_period), 500);
        exp_q.push_back(8'h06);
        frame(8'h12, 8'h01, 8'hF4, 8'hE7);
        exp_cfg++;
        wait_resp();
        chk("t6_duty_eq_period", 32'(duty(2)), 500);
        chk("end_cfg_cnt", cfg_cnt, exp_cfg);
        chk("end_err_cnt", err_cnt, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
